pet_status: RTL

Game-logic stage directly upstream of the display control FSM. It holds the pet's hunger, boredom, dirt, sickness and health, ages them on a slow game tick, and applies the effects of care items. It also runs the wake/sleep cycle and produces the per-frame request flags the control FSM polls: hungerenable, boredenable, sickenable, dirtyenable, dyingenable, zzzsenable and deceased.

---
 rtl/pet_status_if.sv | 34 +++
 rtl/pet_status.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pet_status_if.sv
// pet_status_if
//   Bundles the start accept, the five care-item levels and every pet status
//   output into one connection.
//   master : drives go_start and the item levels, observes the status outputs
//   slave  : the pet_status block itself
interface pet_status_if;
  logic       go_start;
  logic       ballGiven;
  logic       foodGiven;
  logic       broomGiven;
  logic       pillsGiven;
  logic       firstAidGiven;
  logic       hungerenable;
  logic       boredenable;
  logic       sickenable;
  logic       dirtyenable;
  logic       dyingenable;
  logic       zzzsenable;
  logic       deceased;
  logic [6:0] health;
  logic       tick;

  modport master (
    output go_start, ballGiven, foodGiven, broomGiven, pillsGiven, firstAidGiven,
    input  hungerenable, boredenable, sickenable, dirtyenable, dyingenable,
           zzzsenable, deceased, health, tick
  );

  modport slave (
    input  go_start, ballGiven, foodGiven, broomGiven, pillsGiven, firstAidGiven,
    output hungerenable, boredenable, sickenable, dirtyenable, dyingenable,
           zzzsenable, deceased, health, tick
  );
endinterface

// File: rtl/pet_status.sv
// pet_status
//   Pet game-logic stage feeding the display control FSM. Holds hunger,
//   boredom, dirt, sickness and health, ages them on a slow game tick,
//   applies care items (rising edges, honoured only while awake), runs the
//   wake/sleep day cycle and produces registered per-frame request flags.
//
//   Ports
//     clk    : system clock
//     reset  : asynchronous active-low reset
//     bus    : pet_status_if.slave
//              in : go_start, ballGiven, foodGiven, broomGiven, pillsGiven,
//                   firstAidGiven
//              out: hungerenable, boredenable, sickenable, dirtyenable,
//                   dyingenable, zzzsenable, deceased, health[6:0], tick
//
//   Build option
//     PET_SLEEP_EN : when defined, the AWAKE/ASLEEP day cycle is built.
//                    When undefined the pet stays awake until death,
//                    zzzsenable is tied low and AWAKE_TICKS/SLEEP_TICKS are
//                    ignored.
module pet_status #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int NEED_THRESH  = 70,
  parameter int DYING_THRESH = 25,
  parameter int AWAKE_TICKS  = 60,
  parameter int SLEEP_TICKS  = 20
) (
  input logic         clk,
  input logic         reset,
  pet_status_if.slave bus
);

  localparam int              PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [6:0]      NEED_LVL  = 7'(NEED_THRESH);
  localparam logic [6:0]      DYING_LVL = 7'(DYING_THRESH);
  localparam logic [6:0]      SICK_LVL  = 7'd80;
  localparam logic [6:0]      STAT_MAX  = 7'd100;

`ifdef PET_SLEEP_EN
  localparam int              DAY_MAX    = (AWAKE_TICKS > SLEEP_TICKS) ? AWAKE_TICKS : SLEEP_TICKS;
  localparam int              DAY_W      = (DAY_MAX > 1) ? $clog2(DAY_MAX) : 1;
  localparam logic [DAY_W-1:0] AWAKE_LAST = DAY_W'(AWAKE_TICKS - 1);
  localparam logic [DAY_W-1:0] SLEEP_LAST = DAY_W'(SLEEP_TICKS - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_AWAKE = 2'd1, S_ASLEEP = 2'd2, S_DEAD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_AWAKE = 2'd1, S_DEAD = 2'd3} state_t;
  logic [31:0] w_unused_cfg;
  assign w_unused_cfg = AWAKE_TICKS ^ SLEEP_TICKS;
`endif

  // Clamp a signed intermediate into the legal stat range 0..100.
  function automatic logic [6:0] clamp100(input logic signed [8:0] v);
    if (v < 9'sd0)        return 7'd0;
    else if (v > 9'sd100) return 7'd100;
    else                  return v[6:0];
  endfunction

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [6:0]       r_hunger, r_bored, r_dirt, r_health;
  logic             r_sick;
  logic [4:0]       r_prev;
  logic             r_hunger_en, r_bored_en, r_sick_en, r_dirty_en, r_dying_en;
  logic             r_deceased, r_tick;
`ifdef PET_SLEEP_EN
  logic [DAY_W-1:0] r_day;
  logic             r_zzz_en;
`endif

  // Item vector order: ball, food, broom, pills, firstAid.
  logic [4:0] w_items, w_rise, w_item;
  logic       w_awake, w_live, w_tick, w_age;
  logic [8:0] w_hunger_inc, w_health_dec;
  logic [6:0] w_hunger_t, w_hunger_n, w_bored_t, w_bored_n;
  logic [6:0] w_dirt_t, w_dirt_n, w_health_t, w_health_n;
  logic       w_sick_t, w_sick_n;

  assign w_items = {bus.ballGiven, bus.foodGiven, bus.broomGiven, bus.pillsGiven, bus.firstAidGiven};
  assign w_awake = (r_state == S_AWAKE);
`ifdef PET_SLEEP_EN
  assign w_live  = w_awake || (r_state == S_ASLEEP);
`else
  assign w_live  = w_awake;
`endif
  assign w_tick  = w_live && (r_pre == PRE_MAX);
  // Edges are consumed every cycle, so nothing queues outside AWAKE.
  assign w_rise  = w_items & ~r_prev;
  assign w_item  = w_awake ? w_rise : 5'd0;
  assign w_age   = w_tick && w_awake;

  // Tick arithmetic first (_t), then item arithmetic on top (_n).
  always_comb begin
    w_hunger_inc = w_tick ? (w_awake ? 9'd2 : 9'd1) : 9'd0;
    w_hunger_t   = clamp100({2'b00, r_hunger} + w_hunger_inc);
    // Ball and food combine before a single saturation.
    w_hunger_n   = clamp100({2'b00, w_hunger_t} + (w_item[4] ? 9'd5 : 9'd0)
                            - (w_item[3] ? 9'd40 : 9'd0));
    w_bored_t    = clamp100({2'b00, r_bored} + {8'd0, w_age});
    w_bored_n    = clamp100({2'b00, w_bored_t} - (w_item[4] ? 9'd50 : 9'd0));
    w_dirt_t     = clamp100({2'b00, r_dirt} + {8'd0, w_age});
    w_dirt_n     = w_item[2] ? 7'd0 : w_dirt_t;
    w_sick_t     = r_sick | (w_age && (w_dirt_t >= SICK_LVL));
    w_sick_n     = w_sick_t & ~w_item[1];
    // Health penalties use the stats as they stood before this tick.
    w_health_dec = 9'd0;
    if (w_tick)
      w_health_dec = {8'd0, (r_hunger >= NEED_LVL)} + {8'd0, r_sick}
                   + {8'd0, (r_hunger == STAT_MAX)};
    w_health_t   = clamp100({2'b00, r_health} - w_health_dec);
    w_health_n   = clamp100({2'b00, w_health_t} + (w_item[0] ? 9'd30 : 9'd0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_hunger    <= 7'd0;
      r_bored     <= 7'd0;
      r_dirt      <= 7'd0;
      r_sick      <= 1'b0;
      r_health    <= STAT_MAX;
      r_prev      <= 5'd0;
      r_hunger_en <= 1'b0;
      r_bored_en  <= 1'b0;
      r_sick_en   <= 1'b0;
      r_dirty_en  <= 1'b0;
      r_dying_en  <= 1'b0;
      r_deceased  <= 1'b0;
      r_tick      <= 1'b0;
`ifdef PET_SLEEP_EN
      r_day       <= '0;
      r_zzz_en    <= 1'b0;
`endif
    end else begin
      r_prev   <= w_items;
      r_hunger <= w_hunger_n;
      r_bored  <= w_bored_n;
      r_dirt   <= w_dirt_n;
      r_sick   <= w_sick_n;
      r_health <= w_health_n;

      // Prescaler stops as soon as health hits zero so DEAD sees it at 0.
      if (w_live && (r_health != 7'd0))
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
      else
        r_pre <= '0;

      case (r_state)
        S_IDLE: begin
          if (bus.go_start) r_state <= S_AWAKE;
`ifdef PET_SLEEP_EN
          r_day <= '0;
`endif
        end
        S_AWAKE: begin
          if (r_health == 7'd0) begin
            r_state <= S_DEAD;
`ifdef PET_SLEEP_EN
          end else if (w_tick) begin
            if (r_day == AWAKE_LAST) begin
              r_state <= S_ASLEEP;
              r_day   <= '0;
            end else begin
              r_day   <= r_day + 1'b1;
            end
`endif
          end
        end
`ifdef PET_SLEEP_EN
        S_ASLEEP: begin
          if (r_health == 7'd0) begin
            r_state <= S_DEAD;
          end else if (w_tick) begin
            if (r_day == SLEEP_LAST) begin
              r_state <= S_AWAKE;
              r_day   <= '0;
            end else begin
              r_day   <= r_day + 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_DEAD;
      endcase

      // Registered flag outputs, masked outside the live states.
      r_tick      <= w_tick;
      r_hunger_en <= w_live && (r_hunger >= NEED_LVL);
      r_bored_en  <= w_live && (r_bored >= NEED_LVL);
      r_dirty_en  <= w_live && (r_dirt >= NEED_LVL);
      r_sick_en   <= w_live && r_sick;
      r_dying_en  <= w_live && (r_health < DYING_LVL);
      r_deceased  <= (r_state == S_DEAD);
`ifdef PET_SLEEP_EN
      r_zzz_en    <= (r_state == S_ASLEEP);
`endif
    end
  end

  assign bus.hungerenable = r_hunger_en;
  assign bus.boredenable  = r_bored_en;
  assign bus.sickenable   = r_sick_en;
  assign bus.dirtyenable  = r_dirty_en;
  assign bus.dyingenable  = r_dying_en;
  assign bus.deceased     = r_deceased;
  assign bus.health       = r_health;
  assign bus.tick         = r_tick;
`ifdef PET_SLEEP_EN
  assign bus.zzzsenable   = r_zzz_en;
`else
  assign bus.zzzsenable   = 1'b0;
`endif

endmodule
